ft_rx_reader: RTL and testbench

Read-side front end for the FT232H asynchronous FIFO interface: pulls host-to-device bytes from the FT232H by strobing RD#. Assembles them little-endian into DATA_WIDTH words and presents them downstream on a valid/ready port. It is the counterpart of the device-to-host write path and feeds the command decoder.

---
 rtl/ft_pkg.sv | 30 +++
 rtl/ft_sync2.sv | 34 +++
 rtl/ft_rx_reader.sv | 231 +++++++++++++++++++++++
 tb/tb_ft_rx_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared definitions for the FT232H asynchronous FIFO read and write paths.
// Latency: n/a (types, timing constants and elaboration helpers only).
// Backpressure: n/a.
package ft_pkg;

  // Reader sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_RECOVER = 2'd2
  } ft_state_t;

  // FT232H asynchronous FIFO timing, in ns. These are the numbers that the
  // RD_LOW_CYCLES / RD_HIGH_CYCLES parameters must cover at the chosen clk.
  localparam int FT_T_RD_ACTIVE_MIN_NS    = 30;  // RD# low pulse width
  localparam int FT_T_RD_TO_DATA_MAX_NS   = 14;  // RD# low to data valid
  localparam int FT_T_RD_TO_RXF_MAX_NS    = 14;  // RD# high to RXF# high
  localparam int FT_T_RXF_INACTIVE_MIN_NS = 49;  // RXF# high time after a read

  // Number of bytes in a word of the given bit width.
  function automatic int ft_bytes(input int width);
    return width / 8;
  endfunction

  // Index width able to address n items; never narrower than one bit.
  function automatic int ft_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ft_sync2.sv
// Two-flop synchronizer for FT232H status flags (RXF# here, TXE# on the write path).
// Latency: 2 clk cycles from i_async to o_sync.
// Backpressure: none; free-running.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset; both flops go to RST_VAL
//   i_async  in   flag from another clock domain / chip pin
//   o_sync   out  synchronized flag
module ft_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/ft_rx_reader.sv
// FT232H read front end: strobes RD#, packs bytes little-endian into DATA_WIDTH words.
// Latency: RD_LOW_CYCLES+RD_HIGH_CYCLES+1 clk per byte at best; word valid the cycle after its last byte is sampled.
// Backpressure: out_valid/out_ready; the final byte of a word is not strobed while the previous word is still pending.
//
// Optional build macro FT_RX_TIMEOUT_EN: flush a partial word after TIMEOUT_CYCLES
// idle cycles and flag it on out_partial (port exists only with the macro).
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   ft_rxf_n     in   FT232H RXF#, low = byte available (asynchronous)
//   ft_data      in   FT232H data bus, valid while ft_rd_n is low
//   ft_rd_n      out  FT232H RD# strobe, active low
//   out_data     out  assembled word, byte 0 in bits [7:0]
//   out_valid    out  out_data holds an unconsumed word
//   out_ready    in   downstream accepts on out_valid && out_ready
//   busy         out  sequencer is not in IDLE
//   out_partial  out  (FT_RX_TIMEOUT_EN only) out_data is a flushed partial word
module ft_rx_reader
  import ft_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int RD_LOW_CYCLES  = 3,
  parameter int RD_HIGH_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ft_rxf_n,
  input  logic [7:0]            ft_data,
  output logic                  ft_rd_n,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef FT_RX_TIMEOUT_EN
  ,
  output logic                  out_partial
`endif
);

  localparam int BYTES = ft_bytes(DATA_WIDTH);
  localparam int IDX_W = ft_idx_w(BYTES);
  localparam int CNT_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int CNT_W = ft_idx_w(CNT_MAX);

  // Elaboration-time parameter sanity.
  if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
    $error("ft_rx_reader: DATA_WIDTH must be a nonzero multiple of 8");
  end
  if (RD_LOW_CYCLES < 2) begin : g_bad_low
    $error("ft_rx_reader: RD_LOW_CYCLES must be >= 2");
  end
  if (RD_HIGH_CYCLES < 3) begin : g_bad_high
    $error("ft_rx_reader: RD_HIGH_CYCLES must be >= 3");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ft_rx_reader: TIMEOUT_CYCLES must be >= 1");
  end

  ft_state_t             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_byte_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_rd_n;
  logic                  r_busy;

  logic                  w_rxf_s;
  logic                  w_last_byte;
  logic                  w_take;
  logic                  w_slot_busy;
  logic                  w_slot_free;
  logic                  w_sample;
  logic [DATA_WIDTH-1:0] w_word;

  ft_sync2 #(
    .RST_VAL (1'b1)
  ) u_rxf_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (ft_rxf_n),
    .o_sync  (w_rxf_s)
  );

  assign w_last_byte = (r_byte_idx == IDX_W'(BYTES - 1));
  assign w_take      = r_out_valid && out_ready;
  assign w_slot_busy = r_out_valid && !out_ready;
  // Only the byte that completes a word needs the output register; earlier
  // bytes of the next word may be fetched while a word is still pending.
  assign w_slot_free = !(w_last_byte && w_slot_busy);
  assign w_sample    = (r_state == ST_STROBE) && (r_cnt == '0);

  // Shift register with the byte on the bus dropped into the current slot.
  always_comb begin
    w_word = r_shift;
    for (int b = 0; b < BYTES; b++) begin
      if (r_byte_idx == IDX_W'(b)) begin
        w_word[b*8 +: 8] = ft_data;
      end
    end
  end

`ifdef FT_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_out_partial;
  logic                  w_to_run;
  logic                  w_to_hit;
  logic                  w_flush;
  logic [DATA_WIDTH-1:0] w_partial_word;

  assign w_to_run = (r_state == ST_IDLE) && (r_byte_idx != '0) && w_rxf_s;
  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
  assign w_flush  = (r_state == ST_IDLE) && (r_byte_idx != '0) && w_to_hit && !w_slot_busy;

  // Received bytes only; slots at or above byte_idx hold stale data from an
  // earlier word and are forced to zero.
  always_comb begin
    w_partial_word = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (IDX_W'(b) < r_byte_idx) begin
        w_partial_word[b*8 +: 8] = r_shift[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_sample || w_flush) begin
      r_to_cnt <= '0;
    end else if (w_to_run && !w_to_hit) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign out_partial = r_out_partial;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_rd_n      <= 1'b1;
      r_busy      <= 1'b0;
`ifdef FT_RX_TIMEOUT_EN
      r_out_partial <= 1'b0;
`endif
    end else begin
      // Handshake clears the slot; a word loading this cycle overrides below.
      if (w_take) begin
        r_out_valid <= 1'b0;
`ifdef FT_RX_TIMEOUT_EN
        r_out_partial <= 1'b0;
`endif
      end

      case (r_state)
        ST_IDLE: begin
`ifdef FT_RX_TIMEOUT_EN
          if (w_flush) begin
            r_out_data    <= w_partial_word;
            r_out_valid   <= 1'b1;
            r_out_partial <= 1'b1;
            r_byte_idx    <= '0;
          end else
`endif
          if (!w_rxf_s && w_slot_free) begin
            r_state <= ST_STROBE;
            r_rd_n  <= 1'b0;
            r_cnt   <= CNT_W'(RD_LOW_CYCLES - 1);
            r_busy  <= 1'b1;
          end
        end

        ST_STROBE: begin
          // RXF# is not looked at here: once RD# is low the FT232H holds
          // the byte until RD# rises, so the strobe always runs to completion.
          if (r_cnt == '0) begin
            r_shift <= w_word;
            r_rd_n  <= 1'b1;
            r_cnt   <= CNT_W'(RD_HIGH_CYCLES - 1);
            r_state <= ST_RECOVER;
            if (w_last_byte) begin
              r_out_data  <= w_word;
              r_out_valid <= 1'b1;
              r_byte_idx  <= '0;
`ifdef FT_RX_TIMEOUT_EN
              r_out_partial <= 1'b0;
`endif
            end else begin
              r_byte_idx <= r_byte_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_RECOVER: begin
          // Covers the RD#-high to RXF#-high delay plus synchronizer lag, so
          // a stale low on rxf_s cannot trigger a second read.
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_rd_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ft_rd_n   = r_rd_n;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ft_rx_reader.sv
// Testbench for ft_rx_reader: FT232H read-side behavioural model plus word scoreboard.
// Latency: n/a.
// Backpressure: exercises out_ready low with a stream in flight.
module tb_ft_rx_reader;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ft_rxf_n = 1'b1;
  logic [7:0]    ft_data = 8'hEE;
  logic          ft_rd_n;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
`ifdef FT_RX_TIMEOUT_EN
  logic          out_partial;
`endif

  always #5 clk = ~clk;

  ft_rx_reader #(
    .DATA_WIDTH     (DW),
    .RD_LOW_CYCLES  (3),
    .RD_HIGH_CYCLES (4),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ft_rxf_n    (ft_rxf_n),
    .ft_data     (ft_data),
    .ft_rd_n     (ft_rd_n),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
`ifdef FT_RX_TIMEOUT_EN
    ,
    .out_partial (out_partial)
`endif
  );

  typedef struct packed {
    logic          partial;
    logic [DW-1:0] word;
  } exp_t;

  int         n_vec = 0;
  int         n_err = 0;
  exp_t       sb_q[$];
  logic [7:0] host_q[$];
  bit         glitch_next = 1'b0;
  int         pulses = 0;
  int         low_cnt = 0;
  int         high_cnt = 0;
  int         vld_cycles = 0;
  bit         have_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    sb_q.push_back('{partial: 1'b0, word: w});
    host_q.push_back(w[7:0]);
    host_q.push_back(w[15:8]);
  endtask

  task automatic drain(input int budget, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && host_q.size() == 0 && !busy && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_drained"}, done, 1);
    if (!done) begin
      sb_q.delete();
      host_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // FT232H model: RXF# low while bytes are queued, data driven after RD# falls,
  // byte consumed when RD# rises (including a rise caused by reset).
  always begin : ft_model
    ft_rxf_n = 1'b1;
    while (host_q.size() == 0) @(posedge clk);
    #3 ft_rxf_n = 1'b0;
    @(negedge ft_rd_n);
    #2 ft_data = host_q[0];
    if (glitch_next) begin
      #3 ft_rxf_n = 1'b1;
      glitch_next = 1'b0;
    end
    @(posedge ft_rd_n);
    void'(host_q.pop_front());
    ft_rxf_n = 1'b1;
    ft_data  = 8'hEE;
    #50;
  end

  // RD# pulse-width monitor and output scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      low_cnt   = 0;
      high_cnt  = 0;
      have_prev = 1'b0;
    end else begin
      if (!ft_rd_n) begin
        if (low_cnt == 0) begin
          pulses++;
          if (have_prev) check("rd_high_ge4", (high_cnt >= 4), 1);
        end
        low_cnt++;
        high_cnt = 0;
      end else begin
        if (low_cnt != 0) begin
          check("rd_low_width", low_cnt, 3);
          have_prev = 1'b1;
        end
        low_cnt = 0;
        high_cnt++;
      end
      if (out_valid) vld_cycles++;
      if (out_valid && out_ready) begin
        check("sb_has_entry", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("word_data", out_data, e.word);
`ifdef FT_RX_TIMEOUT_EN
          check("word_partial", out_partial, e.partial);
`endif
        end
      end
    end
  end

  initial begin : stim
    int  base;
    bit  done;
    int  cyc;

    // Reset
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_n", ft_rd_n, 1);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;

    // Idle: no RXF#, nothing must happen
    repeat (100) begin
      @(negedge clk);
      check("idle_rd_n", ft_rd_n, 1);
      check("idle_valid", out_valid, 0);
      check("idle_busy", busy, 0);
    end
    @(posedge clk);
    #1;

    // Single word with out_ready high
    out_ready  = 1'b1;
    base       = pulses;
    vld_cycles = 0;
    push_word(16'h1234);
    drain(300, "t2");
    check("t2_pulses", pulses - base, 2);
    check("t2_valid_cycles", vld_cycles, 1);

    // Back-pressure: three words queued, out_ready low
    out_ready = 1'b0;
    base      = pulses;
    push_word(16'h1234);
    push_word(16'h5678);
    push_word(16'h9ABC);
    repeat (300) @(negedge clk);
    check("t3_pulses_blocked", pulses - base, 3);
    check("t3_host_left", host_q.size(), 3);
    check("t3_pending_valid", out_valid, 1);
    check("t3_pending_data", out_data, 16'h1234);
    check("t3_rd_idle", ft_rd_n, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain(600, "t3");
    check("t3_pulses_total", pulses - base, 6);

    // RXF# rises in the middle of a strobe
    base        = pulses;
    glitch_next = 1'b1;
    push_word(16'hC3A5);
    drain(300, "t4");
    check("t4_pulses", pulses - base, 2);

    // Reset while RD# is low on the second byte of a word
    base = pulses;
    done = 1'b0;
    host_q.push_back(8'h11);
    host_q.push_back(8'h22);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pulses == base + 2 && !ft_rd_n) begin
        done = 1'b1;
        break;
      end
    end
    check("t5_second_strobe", done, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_rd_n", ft_rd_n, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", out_data, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5_host_consumed", host_q.size(), 0);
    host_q.delete();
    repeat (10) @(posedge clk);
    #1;
    base = pulses;
    push_word(16'hA55A);
    drain(300, "t5");
    check("t5_pulses", pulses - base, 2);

`ifdef FT_RX_TIMEOUT_EN
    // Single byte, then idle: flushed as a partial word
    out_ready = 1'b0;
    sb_q.push_back('{partial: 1'b1, word: 16'h00AB});
    host_q.push_back(8'hAB);
    done = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("t6_flush_seen", done, 1);
    check("t6_not_early", (cyc >= 1024), 1);
    check("t6_not_late", (cyc <= 1100), 1);
    check("t6_data", out_data, 16'h00AB);
    check("t6_partial", out_partial, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain(100, "t6");
`else
    // Single byte, then idle: the partial word must wait indefinitely
    sb_q.push_back('{partial: 1'b0, word: 16'hCDAB});
    host_q.push_back(8'hAB);
    repeat (1500) @(negedge clk);
    check("t6_no_flush", out_valid, 0);
    check("t6_idle_rd_n", ft_rd_n, 1);
    @(posedge clk);
    #1 host_q.push_back(8'hCD);
    drain(300, "t6");
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
